// File: rtl/w_dsp_pkg.sv
// rtl/w_dsp_pkg.sv - shared state encodings and width helper for the w_ datapath blocks
package w_dsp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } acc_state_t;

    // Smallest r with 2**r >= value; used only in constant contexts.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/w_saturate.sv
// rtl/w_saturate.sv - signed clip from IW to OW bits with a clip flag
module w_saturate #(
    parameter int IW = 12,
    parameter int OW = 10
) (
    input  logic signed [IW-1:0] in_val,
    output logic signed [OW-1:0] out_val,
    output logic                 sat
);

    generate
        if (OW >= IW) begin : g_extend
            assign out_val = OW'(in_val);
            assign sat     = 1'b0;
        end else begin : g_clip
            // Value fits iff every bit from the MSB down to the output sign bit agrees.
            logic [IW-OW:0] hi;
            assign hi      = in_val[IW-1:OW-1];
            assign sat     = ~((&hi) | ~(|hi));
            assign out_val = !sat ? in_val[OW-1:0] :
                             in_val[IW-1] ? {1'b1, {(OW-1){1'b0}}} :
                                            {1'b0, {(OW-1){1'b1}}};
        end
    endgenerate

endmodule

// File: rtl/w_sum_accumulator.sv
// rtl/w_sum_accumulator.sv - sums LEN signed adder samples and presents a saturated result
module w_sum_accumulator
    import w_dsp_pkg::*;
#(
    parameter int N   = 8,
    parameter int LEN = 4,
    parameter int OW  = N + 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [N+1:0]  in_sum,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 clr,
    output logic signed [OW-1:0] out_acc,
    output logic                 out_sat,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int AW = N + 2 + clog2(LEN);
    localparam int CW = clog2(LEN + 1);

    acc_state_t          state;
    logic signed [AW-1:0] acc;
    logic [CW-1:0]        count;
    logic signed [AW-1:0] sum_next;
    logic signed [OW-1:0] sat_val;
    logic                 sat_flag;
    logic                 accept;

    assign in_ready = (state != HOLD);
    assign accept   = in_valid & in_ready;
    assign sum_next = acc + AW'(in_sum);

    w_saturate #(.IW(AW), .OW(OW)) u_sat (
        .in_val  (sum_next),
        .out_val (sat_val),
        .sat     (sat_flag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            out_acc   <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else if (clr) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            out_sat   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc   <= sum_next;
                        count <= count + 1'b1;
                        // The final beat goes straight into the output register.
                        if (count == CW'(LEN - 1)) begin
                            out_acc   <= sat_val;
                            out_sat   <= sat_flag;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        count     <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
